// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register bank with interrupt control:
// reserved register addresses, STATUS bit positions and FSM encoding.
package cp0_pkg;

    localparam int CP_ADDR_COMPARE = 8;
    localparam int CP_ADDR_COUNT   = 9;
    localparam int CP_ADDR_PENDING = 10;
    localparam int CP_ADDR_MASK    = 11;
    localparam int CP_ADDR_STATUS  = 12;
    localparam int CP_ADDR_CAUSE   = 13;
    localparam int CP_ADDR_EPC     = 14;
    localparam int CP_ADDR_EHB     = 15;

    localparam int STATUS_IE_BIT   = 0;

    // Interrupt nesting state: either free to accept or servicing one
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_ISR = 1'b1;

    // Index width helper so single-line configurations still get a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request vector.
module cp0_prio_enc
    import cp0_pkg::*;
#(
    parameter int IRQ_NUM = 8,
    localparam int IDX_W  = idx_width(IRQ_NUM)
) (
    input  logic [IRQ_NUM-1:0] i_req,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_index
);

    assign o_any = |i_req;

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_index = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_irq_regfile.sv
// CP0 register file with integrated interrupt controller: edge capture into
// PENDING, MASK gating, lowest-index priority, IDLE/IN_ISR nesting and ERET.
// Optional build macro CP0_TIMER_EN turns COUNT/COMPARE into a free-running
// timer whose match raises interrupt line IRQ_NUM-1.
module cp0_irq_regfile
    import cp0_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int IRQ_NUM    = 8,
    localparam int IDX_W     = idx_width(IRQ_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  en_w,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [IRQ_NUM-1:0]    irq_in,
    output logic                  irq_req,
    output logic [IDX_W-1:0]      irq_index,
    input  logic                  irq_take,
    input  logic [DATA_WIDTH-1:0] epc_in,
    input  logic                  eret,
    output logic [DATA_WIDTH-1:0] data_r_epc,
    output logic [DATA_WIDTH-1:0] data_r_status,
    output logic [DATA_WIDTH-1:0] data_r_cause,
    output logic [DATA_WIDTH-1:0] data_r_mask
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs      [DEPTH];
    logic [DATA_WIDTH-1:0] w_regs_next [DEPTH];
    logic [IRQ_NUM-1:0]    r_prev;
    logic [0:0]            r_state;

    logic [IRQ_NUM-1:0]    w_rise;
    logic [IRQ_NUM-1:0]    w_timer_vec;
    logic [IRQ_NUM-1:0]    w_pend_eff;
    logic [IRQ_NUM-1:0]    w_masked;
    logic                  w_any;
    logic                  w_take;
    logic                  w_wr_pending;
    logic [DATA_WIDTH-1:0] w_onehot;

    assign w_rise       = irq_in & ~r_prev;
    assign w_wr_pending = en_w && (addr_w == ADDR_WIDTH'(CP_ADDR_PENDING));

`ifdef CP0_TIMER_EN
    logic r_timer_pending;
    logic w_wr_compare;
    logic w_timer_hit;

    assign w_wr_compare = en_w && (addr_w == ADDR_WIDTH'(CP_ADDR_COMPARE));
    assign w_timer_hit  = (r_regs[CP_ADDR_COUNT] == r_regs[CP_ADDR_COMPARE]) &&
                          (r_regs[CP_ADDR_COMPARE] != '0);
    assign w_timer_vec  = IRQ_NUM'(r_timer_pending) << (IRQ_NUM - 1);

    // Timer match flag: a COMPARE write or taking the timer line acknowledges it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer_pending <= 1'b0;
        end else if (w_wr_compare) begin
            r_timer_pending <= 1'b0;
        end else if (w_take && (irq_index == IDX_W'(IRQ_NUM - 1))) begin
            r_timer_pending <= 1'b0;
        end else if (w_timer_hit) begin
            r_timer_pending <= 1'b1;
        end
    end
`else
    assign w_timer_vec = '0;
`endif

    assign w_pend_eff = r_regs[CP_ADDR_PENDING][IRQ_NUM-1:0] | w_timer_vec;
    assign w_masked   = w_pend_eff & r_regs[CP_ADDR_MASK][IRQ_NUM-1:0];

    cp0_prio_enc #(
        .IRQ_NUM (IRQ_NUM)
    ) u_prio (
        .i_req   (w_masked),
        .o_any   (w_any),
        .o_index (irq_index)
    );

    assign irq_req  = (r_state == ST_IDLE) && r_regs[CP_ADDR_STATUS][STATUS_IE_BIT] && w_any;
    assign w_take   = irq_take && irq_req;
    assign w_onehot = DATA_WIDTH'(1) << irq_index;

    // Next register image: software write first, hardware updates layered on top
    // so they win; edge capture is applied last so a new edge beats W1C/take.
    always_comb begin
        w_regs_next = r_regs;
        if (en_w) begin
            if (w_wr_pending) begin
                w_regs_next[CP_ADDR_PENDING] = r_regs[CP_ADDR_PENDING] & ~data_w;
            end else begin
                w_regs_next[addr_w] = data_w;
            end
        end
`ifdef CP0_TIMER_EN
        w_regs_next[CP_ADDR_COUNT] = r_regs[CP_ADDR_COUNT] + DATA_WIDTH'(1);
`endif
        if (eret) begin
            w_regs_next[CP_ADDR_STATUS][STATUS_IE_BIT] = 1'b1;
        end
        if (w_take) begin
            w_regs_next[CP_ADDR_EPC]                   = epc_in;
            w_regs_next[CP_ADDR_CAUSE]                 = w_onehot;
            w_regs_next[CP_ADDR_PENDING]               = w_regs_next[CP_ADDR_PENDING] & ~w_onehot;
            w_regs_next[CP_ADDR_STATUS][STATUS_IE_BIT] = 1'b0;
        end
        w_regs_next[CP_ADDR_PENDING] = w_regs_next[CP_ADDR_PENDING] | DATA_WIDTH'(w_rise);
    end

    // Register bank, edge history and nesting state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_prev  <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_regs <= w_regs_next;
            r_prev <= irq_in;
            if (w_take) begin
                r_state <= ST_IN_ISR;
            end else if (eret) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign data_r        = r_regs[addr_r];
    assign data_r_epc    = r_regs[CP_ADDR_EPC];
    assign data_r_status = r_regs[CP_ADDR_STATUS];
    assign data_r_cause  = r_regs[CP_ADDR_CAUSE];
    assign data_r_mask   = r_regs[CP_ADDR_MASK];

endmodule

// File: tb/tb_cp0_irq_regfile.sv
// Directed bench for cp0_irq_regfile with default parameters (32/4/8).
// The timer scenario is compiled in when CP0_TIMER_EN is defined.
module tb_cp0_irq_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr_r;
    logic [31:0] data_r;
    logic        en_w;
    logic [3:0]  addr_w;
    logic [31:0] data_w;
    logic [7:0]  irq_in;
    logic        irq_req;
    logic [2:0]  irq_index;
    logic        irq_take;
    logic [31:0] epc_in;
    logic        eret;
    logic [31:0] data_r_epc, data_r_status, data_r_cause, data_r_mask;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cp0_irq_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .IRQ_NUM(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_r        (addr_r),
        .data_r        (data_r),
        .en_w          (en_w),
        .addr_w        (addr_w),
        .data_w        (data_w),
        .irq_in        (irq_in),
        .irq_req       (irq_req),
        .irq_index     (irq_index),
        .irq_take      (irq_take),
        .epc_in        (epc_in),
        .eret          (eret),
        .data_r_epc    (data_r_epc),
        .data_r_status (data_r_status),
        .data_r_cause  (data_r_cause),
        .data_r_mask   (data_r_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_write(input logic [3:0] a, input logic [31:0] d);
        en_w = 1'b1; addr_w = a; data_w = d;
        tick();
        en_w = 1'b0;
        $display("mtc0 addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_w = 0; addr_w = 0; data_w = 0; addr_r = 4'd10;
        irq_in = 0; irq_take = 0; epc_in = 0; eret = 0;
        tick();
        n_chk++; if (data_r_status !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", data_r_status); end
        n_chk++; if (data_r_epc !== 32'h0 || data_r_cause !== 32'h0 || data_r_mask !== 32'h0) begin n_fail++; $display("FAIL reset_views: epc %h cause %h mask %h want 0", data_r_epc, data_r_cause, data_r_mask); end
        n_chk++; if (irq_req !== 1'b0 || irq_index !== 3'd0) begin n_fail++; $display("FAIL reset_req: req %b idx %0d want 0/0", irq_req, irq_index); end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_storage();
        sw_write(4'd3, 32'hDEADBEEF);
        sw_write(4'd0, 32'h0000005A);
        addr_r = 4'd3;
        n_chk++; if (data_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL storage_3: got %h want deadbeef", data_r); end
        addr_r = 4'd0;
        n_chk++; if (data_r !== 32'h5A) begin n_fail++; $display("FAIL storage_0: got %h want 5a", data_r); end
        sw_write(4'd8, 32'h55);
        addr_r = 4'd8;
        n_chk++; if (data_r !== 32'h55) begin n_fail++; $display("FAIL storage_compare: got %h want 55", data_r); end
        sw_write(4'd8, 32'h0);
    endtask

    task automatic test_masked();
        sw_write(4'd11, 32'h04);
        sw_write(4'd12, 32'h01);
        irq_in = 8'h04;
        tick();
        addr_r = 4'd10;
        n_chk++; if (irq_req !== 1'b1 || irq_index !== 3'd2) begin n_fail++; $display("FAIL masked_req: req %b idx %0d want 1/2", irq_req, irq_index); end
        n_chk++; if (data_r !== 32'h04) begin n_fail++; $display("FAIL masked_pending: got %h want 4", data_r); end
        irq_take = 1'b1; epc_in = 32'h400;
        tick();
        irq_take = 1'b0;
        $display("take epc=0x400");
        n_chk++; if (data_r_epc !== 32'h400) begin n_fail++; $display("FAIL masked_epc: got %h want 400", data_r_epc); end
        n_chk++; if (data_r_cause !== 32'h4) begin n_fail++; $display("FAIL masked_cause: got %h want 4", data_r_cause); end
        n_chk++; if (data_r_status !== 32'h0) begin n_fail++; $display("FAIL masked_ie: got %h want 0", data_r_status); end
        n_chk++; if (data_r !== 32'h0 || irq_req !== 1'b0) begin n_fail++; $display("FAIL masked_cleared: pending %h req %b want 0/0", data_r, irq_req); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_chk++; if (data_r_status !== 32'h1) begin n_fail++; $display("FAIL masked_eret: got %h want 1", data_r_status); end
        irq_in = 8'h00;
        tick();
    endtask

    task automatic test_priority();
        sw_write(4'd11, 32'hFF);
        irq_in = 8'h28;
        tick();
        addr_r = 4'd10;
        n_chk++; if (irq_req !== 1'b1 || irq_index !== 3'd3) begin n_fail++; $display("FAIL prio_low: req %b idx %0d want 1/3", irq_req, irq_index); end
        irq_take = 1'b1; epc_in = 32'h500;
        tick();
        irq_take = 1'b0;
        n_chk++; if (data_r_cause !== 32'h08 || data_r !== 32'h20) begin n_fail++; $display("FAIL prio_take: cause %h pending %h want 8/20", data_r_cause, data_r); end
        n_chk++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_isr_req: got %b want 0", irq_req); end
        irq_in = 8'h68;
        tick();
        n_chk++; if (data_r !== 32'h60 || irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_isr_latch: pending %h req %b want 60/0", data_r, irq_req); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_chk++; if (irq_req !== 1'b1 || irq_index !== 3'd5) begin n_fail++; $display("FAIL prio_after_eret: req %b idx %0d want 1/5", irq_req, irq_index); end
        sw_write(4'd10, 32'hFF);
        n_chk++; if (data_r !== 32'h0 || irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_w1c: pending %h req %b want 0/0", data_r, irq_req); end
        irq_in = 8'h00;
        tick();
    endtask

    task automatic test_w1c_race();
        en_w = 1'b1; addr_w = 4'd11; data_w = 32'h0F; addr_r = 4'd11;
        #1;
        n_chk++; if (data_r !== 32'hFF) begin n_fail++; $display("FAIL no_bypass: got %h want ff", data_r); end
        tick();
        en_w = 1'b0;
        n_chk++; if (data_r !== 32'h0F) begin n_fail++; $display("FAIL write_lands: got %h want 0f", data_r); end
        sw_write(4'd11, 32'hFF);
        addr_r = 4'd10;
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        n_chk++; if (data_r !== 32'h01) begin n_fail++; $display("FAIL race_setup: got %h want 1", data_r); end
        irq_in = 8'h01;
        en_w = 1'b1; addr_w = 4'd10; data_w = 32'h01;
        tick();
        en_w = 1'b0;
        n_chk++; if (data_r !== 32'h01) begin n_fail++; $display("FAIL race_set_wins: got %h want 1", data_r); end
        sw_write(4'd10, 32'h01);
        n_chk++; if (data_r !== 32'h00) begin n_fail++; $display("FAIL race_plain_w1c: got %h want 0", data_r); end
        irq_in = 8'h00;
        tick();
    endtask

    task automatic test_conflicts();
        irq_in = 8'h02;
        tick();
        n_chk++; if (irq_req !== 1'b1 || irq_index !== 3'd1) begin n_fail++; $display("FAIL conf_req: req %b idx %0d want 1/1", irq_req, irq_index); end
        irq_take = 1'b1; epc_in = 32'h777;
        en_w = 1'b1; addr_w = 4'd14; data_w = 32'h123;
        tick();
        irq_take = 1'b0; en_w = 1'b0;
        n_chk++; if (data_r_epc !== 32'h777 || data_r_cause !== 32'h2) begin n_fail++; $display("FAIL conf_epc_hw: epc %h cause %h want 777/2", data_r_epc, data_r_cause); end
        eret = 1'b1; en_w = 1'b1; addr_w = 4'd12; data_w = 32'h0;
        tick();
        eret = 1'b0; en_w = 1'b0;
        n_chk++; if (data_r_status !== 32'h1) begin n_fail++; $display("FAIL conf_status_hw: got %h want 1", data_r_status); end
        sw_write(4'd12, 32'h0);
        irq_in = 8'h12;
        tick();
        n_chk++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL conf_ie_off: got %b want 0", irq_req); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_chk++; if (data_r_status !== 32'h1 || irq_req !== 1'b1 || irq_index !== 3'd4) begin n_fail++; $display("FAIL conf_eret_idle: status %h req %b idx %0d want 1/1/4", data_r_status, irq_req, irq_index); end
        irq_take = 1'b1; eret = 1'b1; epc_in = 32'h888;
        tick();
        irq_take = 1'b0; eret = 1'b0;
        n_chk++; if (data_r_status !== 32'h0 || data_r_epc !== 32'h888 || irq_req !== 1'b0) begin n_fail++; $display("FAIL conf_take_wins: status %h epc %h req %b want 0/888/0", data_r_status, data_r_epc, irq_req); end
        irq_in = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        addr_r = 4'd10;
        irq_in = 8'h01;
        tick();
        n_chk++; if (data_r !== 32'h01) begin n_fail++; $display("FAIL mid_latch: got %h want 1", data_r); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (data_r_epc !== 0 || data_r_status !== 0 || data_r_cause !== 0 || data_r_mask !== 0 || data_r !== 0) begin n_fail++; $display("FAIL mid_reset_regs: epc %h st %h cause %h mask %h pend %h want 0", data_r_epc, data_r_status, data_r_cause, data_r_mask, data_r); end
        n_chk++; if (irq_req !== 1'b0 || irq_index !== 3'd0) begin n_fail++; $display("FAIL mid_reset_req: req %b idx %0d want 0/0", irq_req, irq_index); end
        irq_in = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset mid-isr");
        sw_write(4'd11, 32'hFF);
        sw_write(4'd12, 32'h01);
        n_chk++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mid_lost: got %b want 0", irq_req); end
        irq_in = 8'h01;
        tick();
        n_chk++; if (irq_req !== 1'b1 || irq_index !== 3'd0) begin n_fail++; $display("FAIL mid_idle: req %b idx %0d want 1/0", irq_req, irq_index); end
        sw_write(4'd10, 32'hFF);
        irq_in = 8'h00;
        tick();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        logic [31:0] c0;
        bit          seen;
        addr_r = 4'd9;
        c0 = data_r;
        tick();
        n_chk++; if (data_r !== c0 + 32'd1) begin n_fail++; $display("FAIL timer_count: got %h want %h", data_r, c0 + 32'd1); end
        sw_write(4'd8, data_r + 32'd6);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (irq_req) seen = 1'b1;
            else tick();
        end
        n_chk++; if (!seen || irq_index !== 3'd7) begin n_fail++; $display("FAIL timer_req: seen %b idx %0d want 1/7", seen, irq_index); end
        sw_write(4'd8, 32'h0);
        n_chk++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL timer_clear: got %b want 0", irq_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_storage();
        test_masked();
        test_priority();
        test_w1c_race();
        test_conflicts();
        test_reset_mid();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
